// File: rtl/pixel_row_sched_if.sv
// Avalon-MM slave bus carrying CPU configuration, acknowledge and status reads
// for the pixel_row scheduler.
interface pixel_row_sched_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pixel_row_sched.sv
// Row request scheduler between VGA timing and the pixel_row PIO: maps raw rows
// through a wrapping vertical offset, holds one pending plus one queued request.
module pixel_row_sched #(
   parameter int ROW_W    = 10,
   parameter int NUM_ROWS = 480,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pixel_row_sched_if.slave     bus,
   input  logic                 row_req,
   input  logic [ROW_W-1:0]     row_num,
   output logic [15:0]          pixel_row,
   output logic                 irq
);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_IDLE,
      ST_BUSY,
      ST_BUSY_Q
   } state_t;

   localparam logic [ROW_W:0]   NROWS   = (ROW_W+1)'(NUM_ROWS);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic               enable_q, enable_d;
   logic               irq_en_q, irq_en_d;
   logic [ROW_W-1:0]   offset_q, offset_d;
   logic [ROW_W-1:0]   cur_row_q, cur_row_d;
   logic [ROW_W-1:0]   next_row_q, next_row_d;
   logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
   logic               ovf_sticky_q, ovf_sticky_d;
   logic [15:0]        pixel_row_q, pixel_row_d;
   logic [31:0]        readdata_q, readdata_d;

   logic               wr;
   logic               wr_ack;
   logic               wr_cfg;
   logic               wr_clr;
   logic [ROW_W-1:0]   cfg_offset;
   logic               req_ok;
   logic [ROW_W-1:0]   map_row;
   logic               overrun;
   logic               unused_wd;

   assign wr         = bus.chipselect & ~bus.write_n;
   assign wr_ack     = wr & (bus.address == 2'd1) & bus.writedata[0];
   assign wr_cfg     = wr & (bus.address == 2'd2);
   assign wr_clr     = wr & (bus.address == 2'd3);
   assign cfg_offset = bus.writedata[16 +: ROW_W];
   assign req_ok     = row_req & ({1'b0, row_num} < NROWS);
   assign unused_wd  = ^{bus.writedata[31:16+ROW_W], bus.writedata[15:2]};

   // Both operands are below NUM_ROWS, so one conditional subtract wraps the sum.
   always_comb begin : map_calc
      logic [ROW_W:0] sum;
      sum = {1'b0, row_num} + {1'b0, offset_q};
      if (sum >= NROWS) begin
         sum = sum - NROWS;
      end
      map_row = sum[ROW_W-1:0];
   end

   always_comb begin : cfg_next
      enable_d = enable_q;
      irq_en_d = irq_en_q;
      offset_d = offset_q;
      if (wr_cfg) begin
         enable_d = bus.writedata[0];
         irq_en_d = bus.writedata[1];
         if ({1'b0, cfg_offset} < NROWS) begin
            offset_d = cfg_offset;
         end
      end
   end

   // State OFF tracks enable exactly, so a disable write wins over any request or ack.
   always_comb begin : fsm_next
      state_d    = state_q;
      cur_row_d  = cur_row_q;
      next_row_d = next_row_q;
      overrun    = 1'b0;
      if (!enable_d) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_IDLE;
            end
            ST_IDLE: begin
               if (req_ok) begin
                  cur_row_d = map_row;
                  state_d   = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (wr_ack && req_ok) begin
                  cur_row_d = map_row;
               end else if (wr_ack) begin
                  state_d = ST_IDLE;
               end else if (req_ok) begin
                  next_row_d = map_row;
                  state_d    = ST_BUSY_Q;
               end
            end
            ST_BUSY_Q: begin
               if (wr_ack) begin
                  cur_row_d = next_row_q;
                  if (!req_ok) begin
                     state_d = ST_BUSY;
                  end
               end
               if (req_ok) begin
                  next_row_d = map_row;
                  overrun    = ~wr_ack;
               end
            end
            default: begin
               state_d = ST_OFF;
            end
         endcase
      end
   end

   always_comb begin : ovf_next
      ovf_cnt_d    = ovf_cnt_q;
      ovf_sticky_d = ovf_sticky_q;
      if (wr_clr) begin
         ovf_cnt_d    = '0;
         ovf_sticky_d = 1'b0;
      end else if (overrun) begin
         ovf_sticky_d = 1'b1;
         if (ovf_cnt_q != '1) begin
            ovf_cnt_d = ovf_cnt_q + CNT_ONE;
         end
      end
   end

   always_comb begin : status_next
      pixel_row_d              = '0;
      pixel_row_d[15]          = (state_d == ST_BUSY) || (state_d == ST_BUSY_Q);
      pixel_row_d[14]          = ovf_sticky_d;
      pixel_row_d[ROW_W-1:0]   = cur_row_d;
   end

   always_comb begin : read_mux
      readdata_d = '0;
      case (bus.address)
         2'd0: begin
            readdata_d[15:0] = pixel_row_q;
         end
         2'd2: begin
            readdata_d[16 +: ROW_W] = offset_q;
            readdata_d[1]           = irq_en_q;
            readdata_d[0]           = enable_q;
         end
         2'd3: begin
            readdata_d[CNT_W-1:0] = ovf_cnt_q;
         end
         default: begin
            readdata_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_OFF;
         enable_q     <= 1'b0;
         irq_en_q     <= 1'b0;
         offset_q     <= '0;
         cur_row_q    <= '0;
         next_row_q   <= '0;
         ovf_cnt_q    <= '0;
         ovf_sticky_q <= 1'b0;
         pixel_row_q  <= '0;
         readdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         irq_en_q     <= irq_en_d;
         offset_q     <= offset_d;
         cur_row_q    <= cur_row_d;
         next_row_q   <= next_row_d;
         ovf_cnt_q    <= ovf_cnt_d;
         ovf_sticky_q <= ovf_sticky_d;
         pixel_row_q  <= pixel_row_d;
         readdata_q   <= readdata_d;
      end
   end

   assign pixel_row    = pixel_row_q;
   assign irq          = irq_en_q & pixel_row_q[15];
   assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_pixel_row_sched.sv
// Self-checking bench for pixel_row_sched: directed vector table, corner-case
// sequences and randomized traffic against a queue-depth reference model.
module tb_pixel_row_sched;
   localparam int ROW_W    = 10;
   localparam int NUM_ROWS = 480;
   localparam int CNT_W    = 8;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             row_req;
   logic [ROW_W-1:0] row_num;
   logic [15:0]      pixel_row;
   logic             irq;

   pixel_row_sched_if bus();

   pixel_row_sched #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .row_req   (row_req),
      .row_num   (row_num),
      .pixel_row (pixel_row),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: enable flag plus number of outstanding rows (0..2).
   bit m_en, m_irqen, m_sticky;
   int m_off, m_pend, m_cur, m_nxt, m_cnt;

   function automatic void model_reset();
      m_en = 0; m_irqen = 0; m_sticky = 0;
      m_off = 0; m_pend = 0; m_cur = 0; m_nxt = 0; m_cnt = 0;
   endfunction

   function automatic logic [15:0] m_pixel();
      int v;
      v = m_cur;
      if (m_pend > 0) v += 32'h8000;
      if (m_sticky)   v += 32'h4000;
      return 16'(v);
   endfunction

   function automatic logic [31:0] m_read(input int a);
      case (a)
         0: return {16'h0, m_pixel()};
         2: return (32'(m_off) << 16) | (m_irqen ? 32'd2 : 32'd0) | (m_en ? 32'd1 : 32'd0);
         3: return 32'(m_cnt);
         default: return 32'h0;
      endcase
   endfunction

   function automatic void model_step(input bit cs, input bit wn, input int addr,
                                      input logic [31:0] wd, input bit req, input int row);
      bit wr, ack, cfg, clr, en_next, valid, ovr;
      int mrow;
      wr      = cs && !wn;
      ack     = wr && addr == 1 && wd[0];
      cfg     = wr && addr == 2;
      clr     = wr && addr == 3;
      en_next = cfg ? wd[0] : m_en;
      valid   = req && row < NUM_ROWS;
      mrow    = (row + m_off) % NUM_ROWS;
      ovr     = 0;
      if (m_en && en_next) begin
         if (m_pend == 0) begin
            if (valid) begin m_cur = mrow; m_pend = 1; end
         end else if (m_pend == 1) begin
            if (ack && valid) m_cur = mrow;
            else if (ack) m_pend = 0;
            else if (valid) begin m_nxt = mrow; m_pend = 2; end
         end else begin
            if (ack) begin
               m_cur = m_nxt;
               if (valid) m_nxt = mrow; else m_pend = 1;
            end else if (valid) begin
               m_nxt = mrow; ovr = 1;
            end
         end
      end else if (!en_next) begin
         m_pend = 0;
      end
      if (clr) begin
         m_cnt = 0; m_sticky = 0;
      end else if (ovr) begin
         m_sticky = 1;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (cfg) begin
         m_irqen = wd[1];
         if (int'(wd[25:16]) < NUM_ROWS) m_off = int'(wd[25:16]);
      end
      m_en = en_next;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input bit cs, input bit wn, input int addr, input logic [31:0] wd,
                       input bit req, input int row, input string tag);
      logic [31:0] exp_rd;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.address    = 2'(addr);
      bus.writedata  = wd;
      row_req        = req;
      row_num        = ROW_W'(row);
      exp_rd = m_read(addr);
      model_step(cs, wn, addr, wd, req, row);
      @(posedge clk);
      #1;
      chk({tag, " pixel_row"}, {16'h0, pixel_row}, {16'h0, m_pixel()});
      chk({tag, " irq"}, {31'h0, irq}, {31'h0, m_irqen && m_pend > 0});
      chk({tag, " readdata"}, bus.readdata, exp_rd);
      row_req        = 1'b0;
      bus.chipselect = 1'b0;
   endtask

   typedef struct {
      bit          cs;
      bit          wn;
      int          addr;
      logic [31:0] wd;
      bit          req;
      int          row;
      logic [15:0] pr;
      bit          irq;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[27];

   initial begin
      tbl[0]  = '{0, 1, 0, 32'h0,        0, 0,   16'h0000, 0, 32'h0};
      tbl[1]  = '{0, 1, 1, 32'h0,        0, 0,   16'h0000, 0, 32'h0};
      tbl[2]  = '{0, 1, 2, 32'h0,        0, 0,   16'h0000, 0, 32'h0};
      tbl[3]  = '{0, 1, 3, 32'h0,        0, 0,   16'h0000, 0, 32'h0};
      tbl[4]  = '{0, 1, 0, 32'h0,        1, 5,   16'h0000, 0, 32'h0};
      tbl[5]  = '{1, 0, 2, 32'h3,        0, 0,   16'h0000, 0, 32'h0};
      tbl[6]  = '{0, 1, 2, 32'h0,        1, 5,   16'h8005, 1, 32'h3};
      tbl[7]  = '{1, 0, 1, 32'h1,        0, 0,   16'h0005, 0, 32'h0};
      tbl[8]  = '{0, 1, 0, 32'h0,        0, 0,   16'h0005, 0, 32'h5};
      tbl[9]  = '{1, 0, 2, 32'h000A0001, 0, 0,   16'h0005, 0, 32'h3};
      tbl[10] = '{0, 1, 2, 32'h0,        1, 475, 16'h8005, 0, 32'h000A0001};
      tbl[11] = '{1, 0, 1, 32'h1,        0, 0,   16'h0005, 0, 32'h0};
      tbl[12] = '{0, 1, 0, 32'h0,        1, 480, 16'h0005, 0, 32'h5};
      tbl[13] = '{1, 0, 2, 32'h01F40001, 0, 0,   16'h0005, 0, 32'h000A0001};
      tbl[14] = '{0, 1, 2, 32'h0,        0, 0,   16'h0005, 0, 32'h000A0001};
      tbl[15] = '{1, 0, 2, 32'h3,        0, 0,   16'h0005, 0, 32'h000A0001};
      tbl[16] = '{0, 1, 3, 32'h0,        1, 1,   16'h8001, 1, 32'h0};
      tbl[17] = '{0, 1, 3, 32'h0,        1, 2,   16'h8001, 1, 32'h0};
      tbl[18] = '{0, 1, 3, 32'h0,        1, 3,   16'hC001, 1, 32'h0};
      tbl[19] = '{0, 1, 3, 32'h0,        0, 0,   16'hC001, 1, 32'h1};
      tbl[20] = '{1, 0, 1, 32'h1,        0, 0,   16'hC003, 1, 32'h0};
      tbl[21] = '{1, 0, 3, 32'h0,        0, 0,   16'h8003, 1, 32'h1};
      tbl[22] = '{0, 1, 3, 32'h0,        0, 0,   16'h8003, 1, 32'h0};
      tbl[23] = '{0, 1, 3, 32'h0,        1, 4,   16'h8003, 1, 32'h0};
      tbl[24] = '{1, 0, 1, 32'h1,        1, 7,   16'h8004, 1, 32'h0};
      tbl[25] = '{0, 1, 3, 32'h0,        0, 0,   16'h8004, 1, 32'h0};
      tbl[26] = '{1, 0, 1, 32'h1,        0, 0,   16'h8007, 1, 32'h0};

      reset_n        = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 2'd0;
      bus.writedata  = '0;
      row_req        = 1'b0;
      row_num        = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset pixel_row", {16'h0, pixel_row}, 32'h0);
      chk("reset irq", {31'h0, irq}, 32'h0);
      chk("reset readdata", bus.readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, tbl[i].req, tbl[i].row,
              $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl pixel_row", i), {16'h0, pixel_row}, {16'h0, tbl[i].pr});
         chk($sformatf("vec%0d tbl irq", i), {31'h0, irq}, {31'h0, tbl[i].irq});
         chk($sformatf("vec%0d tbl readdata", i), bus.readdata, tbl[i].rd);
      end

      // Saturating overrun counter.
      step(0, 1, 3, 0, 1, 8, "sat fill");
      for (int i = 0; i < 260; i++) step(0, 1, 3, 0, 1, i + 10, "sat run");
      step(0, 1, 3, 0, 0, 0, "sat read");
      chk("sat ovf_cnt", bus.readdata, 32'hFF);
      chk("sat sticky", {31'h0, pixel_row[14]}, 32'h1);

      // Clear coincident with an overrun: clear wins.
      step(1, 0, 3, 0, 1, 20, "clr race");
      step(0, 1, 3, 0, 0, 0, "clr read");
      chk("clr ovf_cnt", bus.readdata, 32'h0);
      chk("clr sticky", {31'h0, pixel_row[14]}, 32'h0);

      // Disable from BUSY_Q with a simultaneous request, then re-enable and ack.
      step(0, 1, 0, 0, 1, 21, "dis fill");
      step(1, 0, 2, 32'h0, 1, 30, "disable");
      chk("dis pending", {31'h0, pixel_row[15]}, 32'h0);
      chk("dis irq", {31'h0, irq}, 32'h0);
      step(1, 0, 2, 32'h3, 0, 0, "reenable");
      step(1, 0, 1, 32'h1, 0, 0, "idle ack");
      chk("idle ack pending", {31'h0, pixel_row[15]}, 32'h0);

      // Asynchronous reset while a row is pending.
      step(0, 1, 0, 0, 1, 9, "pre reset");
      chk("pre reset pending", {31'h0, pixel_row[15]}, 32'h1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async reset pixel_row", {16'h0, pixel_row}, 32'h0);
      chk("async reset irq", {31'h0, irq}, 32'h0);
      chk("async reset readdata", bus.readdata, 32'h0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Randomized traffic against the model.
      step(1, 0, 2, 32'h3, 0, 0, "rnd enable");
      for (int i = 0; i < 3000; i++) begin
         bit          cs, wn, req;
         int          addr, row;
         logic [31:0] wd;
         cs   = $urandom_range(0, 99) < 30;
         wn   = $urandom_range(0, 3) == 0;
         addr = $urandom_range(0, 3);
         wd   = $urandom;
         if (addr == 2) begin
            wd[0]     = $urandom_range(0, 9) != 0;
            wd[25:16] = 10'($urandom_range(0, 511));
         end
         req = $urandom_range(0, 2) != 0;
         row = $urandom_range(0, 511);
         step(cs, wn, addr, wd, req, row, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_row_sched.md
Name: pixel_row_sched

Overview:
Scheduler sitting between the VGA timing generator and the CPU-readable pixel_row PIO. It captures per-line row requests, maps each to a display row with a programmable vertical offset, and presents the current row and status on a 16-bit word for the PIO input. It holds at most one queued request, raises an interrupt while a row is pending, and counts overruns. The CPU configures and acknowledges it through a 4-word Avalon-MM slave.

Parameters:
ROW_W, 10, width of row numbers (ROW_W <= 14)
NUM_ROWS, 480, number of visible rows; mapped rows wrap modulo this
CNT_W, 8, overrun counter width

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
address  in  2  Avalon slave word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
row_req  in  1  single-cycle request pulse from VGA timing at start of horizontal blank
row_num  in  ROW_W  raw row number, valid with row_req
pixel_row  out  16  to PIO in_port: {pending, ovf_sticky, zero pad, cur_row}
irq  out  1  interrupt, level

Behaviour:
- Reset: state OFF, readdata=0, pixel_row=0, irq=0, enable=0, irq_en=0, offset=0, cur_row=0, next_row=0, ovf_cnt=0, ovf_sticky=0.
- Write = chipselect & ~write_n. addr0: no effect. addr1: writedata[0]=1 is ack. addr2: enable=wd[0], irq_en=wd[1], offset=wd[16+ROW_W-1:16]; offset ignored (kept) if >= NUM_ROWS. addr3: any write clears ovf_cnt and ovf_sticky.
- Read mux, registered every clock regardless of chipselect (1-cycle latency): addr0 {16'b0,pixel_row}; addr1 0; addr2 {offset at 16+, irq_en bit1, enable bit0}; addr3 {zero, ovf_cnt}.
- Mapping: m = row_num + offset; if m >= NUM_ROWS then m -= NUM_ROWS. row_req with row_num >= NUM_ROWS is ignored.
- FSM states OFF, IDLE, BUSY (one pending), BUSY_Q (pending + one queued):
  OFF: row_req ignored; enable=1 -> IDLE next cycle.
  IDLE: row_req -> cur_row<=m, BUSY.
  BUSY: ack -> IDLE; row_req -> next_row<=m, BUSY_Q; ack & row_req same cycle -> cur_row<=m, stay BUSY.
  BUSY_Q: ack -> cur_row<=next_row, BUSY; row_req without ack -> next_row<=m (old dropped), ovf_cnt+1 saturating at all-ones, ovf_sticky<=1; ack & row_req -> cur_row<=next_row, next_row<=m, stay BUSY_Q, no overrun.
  Ack in OFF/IDLE: no effect.
- enable written 0 from any state -> OFF next cycle; pending/queued requests discarded, cur_row retained, ovf_cnt/ovf_sticky retained. Disable has priority over a same-cycle row_req or ack.
- Overrun clear (addr3 write) coincident with overrun event: clear wins, counter = 0, sticky = 0.
- pixel_row[15] = state in {BUSY,BUSY_Q}; [14] = ovf_sticky; [ROW_W-1:0] = cur_row; rest 0. Registered, updates the cycle after the causing event.
- irq = irq_en & pixel_row[15].
- Reset asserted mid-operation: all state returns to reset values immediately.

Test Plan:
- Reset, read addr0..3 -> all readdata 0, pixel_row=0, irq=0; row_req while OFF -> no change.
- Write addr2=0x0000_0003, row_req row_num=5 -> pixel_row=0x8005, irq=1; write addr1=1 -> pixel_row=0x0005, irq=0.
- offset=10 (addr2=0x000A_0001), row_req row_num=475 -> cur_row=5 (wrap); row_num=480 -> ignored; write offset=500 -> offset stays 10.
- Enabled: requests 1,2,3 without ack -> cur_row=1, next_row=3, ovf_cnt=1, pixel_row=0xC001; ack -> cur_row=3; write addr3 -> ovf_cnt=0, bit14 clear.
- BUSY_Q with ack and row_req=7 same cycle -> cur_row=old next, next_row=7, ovf_cnt unchanged; 256 overruns with CNT_W=8 -> ovf_cnt=255.
- In BUSY_Q write addr2=0 -> OFF, pixel_row[15]=0, irq=0; re-enable and ack -> no effect; assert reset_n=0 mid-BUSY -> all outputs 0 asynchronously.
